// File: rtl/spw_link_ctrl_pkg.sv
// Shared FSM state type, core state encodings and small helpers for the
// SpaceWire link-control wrapper.
package spw_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DISABLE = 3'd3,
    ST_FAIL    = 3'd4
  } link_state_e;

  localparam logic [2:0] CS_ERRORRESET = 3'd0;
  localparam logic [2:0] CS_ERRORWAIT  = 3'd1;
  localparam logic [2:0] CS_READY      = 3'd2;
  localparam logic [2:0] CS_STARTED    = 3'd3;
  localparam logic [2:0] CS_CONNECTING = 3'd4;
  localparam logic [2:0] CS_RUN        = 3'd5;

  function automatic logic [1:0] sat_inc2(input logic [1:0] val, input logic [1:0] lim);
    if (val >= lim) begin
      return val;
    end else begin
      return val + 2'd1;
    end
  endfunction

endpackage

// File: rtl/spw_rx_fetch.sv
// Pulls one word at a time from the core RX FIFO and presents it to the host
// with a valid/ready hold; an issued read always completes.
module spw_rx_fetch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       rx_empty,
  input  logic [8:0] data_o,
  input  logic       rx_ready,
  output logic       rd_data,
  output logic       rx_valid,
  output logic [8:0] rx_data
);

  logic       rd_r;
  logic       pend_r;
  logic       valid_r;
  logic [8:0] data_r;
  logic       issue_s;

  assign issue_s = run & ~rx_empty & ~rd_r & ~pend_r & ~valid_r;

  // read pulse, one cycle for FIFO data to appear, then hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r    <= 1'b0;
      pend_r  <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= 9'd0;
    end else begin
      rd_r   <= issue_s;
      pend_r <= rd_r;
      if (pend_r) begin
        valid_r <= 1'b1;
        data_r  <= data_o;
      end else if (valid_r && rx_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign rd_data  = rd_r;
  assign rx_valid = valid_r;
  assign rx_data  = data_r;

endmodule

// File: rtl/spw_link_ctrl.sv
// Link bring-up supervisor for a SpaceWire core: start/timeout/retry FSM plus
// host-side TX, RX and timecode plumbing.
module spw_link_ctrl
  import spw_link_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000,
  parameter int MAX_RETRY   = 3,
  parameter int DIS_CYC     = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       enable,
  input  logic [6:0] cfg_tx_clk_div,
  input  logic [2:0] currentstate,
  output logic       link_start,
  output logic       autostart,
  output logic       link_disable,
  output logic [6:0] tx_clk_div,
  input  logic       tx_valid,
  input  logic [8:0] tx_data,
  output logic       tx_ready,
  output logic       wr_data,
  output logic [8:0] data_i,
  input  logic       tx_full,
  output logic       rd_data,
  input  logic [8:0] data_o,
  input  logic       rx_empty,
  output logic       rx_valid,
  output logic [8:0] rx_data,
  input  logic       rx_ready,
  input  logic       tick_req,
  input  logic [7:0] time_req,
  output logic       tick_in,
  output logic [7:0] time_in,
  output logic       link_up,
  output logic       link_fail,
  output logic [1:0] retry_cnt
);

  localparam int CNT_MAX = (TIMEOUT_CYC > DIS_CYC) ? TIMEOUT_CYC : DIS_CYC;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] DIS_LAST  = TW'(DIS_CYC - 1);
  localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);

  logic [1:0]    rst_sync_r;
  logic          rst_n_s;
  link_state_e   state_r, state_next_s;
  logic [TW-1:0] timer_r, timer_next_s;
  logic [1:0]    retry_r, retry_next_s;
  logic          latch_div_s;
  logic [6:0]    div_r;
  logic          start_r, disable_r, up_r, fail_r;
  logic          run_s, tx_ready_s, tick_ok_s;
  logic          wr_r, tick_r, tick_req_d_r;
  logic [8:0]    di_r;
  logic [7:0]    time_r;

  // reset asserts asynchronously, releases two edges later
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  // next-state logic; host enable overrides core state and timeout
  always_comb begin
    state_next_s = state_r;
    timer_next_s = timer_r;
    retry_next_s = retry_r;
    latch_div_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_next_s = ST_START;
          timer_next_s = '0;
          latch_div_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (!enable) begin
          state_next_s = ST_DISABLE;
          timer_next_s = '0;
        end else if (currentstate == CS_RUN) begin
          state_next_s = ST_RUN;
          timer_next_s = '0;
          retry_next_s = 2'd0;
        end else if (timer_r == TO_LAST) begin
          state_next_s = ST_DISABLE;
          timer_next_s = '0;
          retry_next_s = sat_inc2(retry_r, RETRY_LIM);
        end else begin
          timer_next_s = timer_r + TW'(1);
        end
      end
      ST_DISABLE: begin
        if (timer_r == DIS_LAST) begin
          timer_next_s = '0;
          if (!enable) begin
            state_next_s = ST_IDLE;
          end else if (retry_r >= RETRY_LIM) begin
            state_next_s = ST_FAIL;
          end else begin
            state_next_s = ST_START;
          end
        end else begin
          timer_next_s = timer_r + TW'(1);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_next_s = ST_DISABLE;
          timer_next_s = '0;
        end else if (currentstate != CS_RUN) begin
          state_next_s = ST_START;
          timer_next_s = '0;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FAIL: begin
        if (!enable) begin
          state_next_s = ST_IDLE;
          retry_next_s = 2'd0;
        end else begin
          state_next_s = ST_FAIL;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        timer_next_s = '0;
        retry_next_s = 2'd0;
      end
    endcase
  end

  // state, counters and registered control decode of the next state
  always_ff @(posedge clk_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r   <= ST_IDLE;
      timer_r   <= '0;
      retry_r   <= 2'd0;
      div_r     <= 7'd0;
      start_r   <= 1'b0;
      disable_r <= 1'b0;
      up_r      <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      timer_r   <= timer_next_s;
      retry_r   <= retry_next_s;
      if (latch_div_s) div_r <= cfg_tx_clk_div;
      start_r   <= (state_next_s == ST_START) || (state_next_s == ST_RUN);
      disable_r <= (state_next_s == ST_DISABLE) || (state_next_s == ST_FAIL);
      up_r      <= (state_next_s == ST_RUN);
      fail_r    <= (state_next_s == ST_FAIL);
    end
  end

  assign run_s      = (state_r == ST_RUN);
  // bubble after each write gives the core a cycle to raise tx_full
  assign tx_ready_s = run_s & ~tx_full & ~wr_r;
  // a tick coinciding with link loss is dropped
  assign tick_ok_s  = run_s & (state_next_s == ST_RUN) & tick_req & ~tick_req_d_r;

  // TX write pulse and timecode edge detection
  always_ff @(posedge clk_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_r         <= 1'b0;
      di_r         <= 9'd0;
      tick_req_d_r <= 1'b0;
      tick_r       <= 1'b0;
      time_r       <= 8'd0;
    end else begin
      wr_r         <= tx_valid & tx_ready_s;
      if (tx_valid && tx_ready_s) di_r <= tx_data;
      tick_req_d_r <= tick_req;
      tick_r       <= tick_ok_s;
      if (tick_ok_s) time_r <= time_req;
    end
  end

  spw_rx_fetch u_rx_fetch (
    .clk      (clk_clk),
    .rst_n    (rst_n_s),
    .run      (run_s),
    .rx_empty (rx_empty),
    .data_o   (data_o),
    .rx_ready (rx_ready),
    .rd_data  (rd_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  assign link_start   = start_r;
  assign autostart    = start_r;
  assign link_disable = disable_r;
  assign link_up      = up_r;
  assign link_fail    = fail_r;
  assign retry_cnt    = retry_r;
  assign tx_clk_div   = div_r;
  assign tx_ready     = tx_ready_s;
  assign wr_data      = wr_r;
  assign data_i       = di_r;
  assign tick_in      = tick_r;
  assign time_in      = time_r;

endmodule

// File: tb/tb_spw_link_ctrl.sv
// Randomised bench for spw_link_ctrl against a cycle-level behavioural model
// of the link supervisor, with directed bring-up, failure and reset scenarios.
module tb_spw_link_ctrl;

  localparam int TIMEOUT_CYC = 2000;
  localparam int MAX_RETRY   = 3;
  localparam int DIS_CYC     = 16;
  localparam int M_IDLE = 10, M_START = 11, M_DIS = 12, M_RUN = 13, M_FAIL = 14;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n, enable, tx_valid, tx_full, rx_empty, rx_ready, tick_req;
  logic [6:0] cfg_tx_clk_div;
  logic [2:0] currentstate;
  logic [8:0] tx_data, data_o;
  logic [7:0] time_req;
  logic       link_start, autostart, link_disable, tx_ready, wr_data, rd_data;
  logic       rx_valid, tick_in, link_up, link_fail;
  logic [6:0] tx_clk_div;
  logic [8:0] data_i, rx_data;
  logic [7:0] time_in;
  logic [1:0] retry_cnt;

  always #5 clk_clk = ~clk_clk;

  spw_link_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY), .DIS_CYC(DIS_CYC)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .cfg_tx_clk_div(cfg_tx_clk_div), .currentstate(currentstate),
    .link_start(link_start), .autostart(autostart), .link_disable(link_disable),
    .tx_clk_div(tx_clk_div), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .wr_data(wr_data), .data_i(data_i), .tx_full(tx_full),
    .rd_data(rd_data), .data_o(data_o), .rx_empty(rx_empty),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tick_req(tick_req), .time_req(time_req), .tick_in(tick_in), .time_in(time_in),
    .link_up(link_up), .link_fail(link_fail), .retry_cnt(retry_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: phase of the link, cycles spent in it, attempts used
  int         m_mode, m_ph, m_retry, m_sync, m_rx;
  logic [6:0] m_div;
  logic       m_wr, m_tick, m_prev_tick;
  logic [8:0] m_di, m_rxd;
  logic [7:0] m_time;

  function automatic void model_reset();
    m_mode = M_IDLE; m_ph = 0; m_retry = 0; m_sync = 0; m_rx = 0;
    m_div = 7'd0; m_wr = 1'b0; m_tick = 1'b0; m_prev_tick = 1'b0;
    m_di = 9'd0; m_rxd = 9'd0; m_time = 8'd0;
  endfunction

  // advance the model across one rising edge using the inputs now applied
  function automatic void model_step();
    int nm, nr, nrx;
    bit in_run, rdy;
    if (!reset_reset_n) begin
      model_reset();
    end else if (m_sync < 2) begin
      m_sync++;
    end else begin
      in_run = (m_mode == M_RUN);
      nm = m_mode; nr = m_retry;
      case (m_mode)
        M_IDLE:  if (enable) begin nm = M_START; m_div = cfg_tx_clk_div; end
        M_START: if (!enable) nm = M_DIS;
                 else if (currentstate == 3'd5) begin nm = M_RUN; nr = 0; end
                 else if (m_ph + 1 >= TIMEOUT_CYC) begin
                   nm = M_DIS; nr = (m_retry + 1 > MAX_RETRY) ? MAX_RETRY : m_retry + 1;
                 end
        M_DIS:   if (m_ph + 1 >= DIS_CYC) begin
                   if (!enable) nm = M_IDLE;
                   else if (m_retry >= MAX_RETRY) nm = M_FAIL;
                   else nm = M_START;
                 end
        M_RUN:   if (!enable) nm = M_DIS; else if (currentstate != 3'd5) nm = M_START;
        M_FAIL:  if (!enable) begin nm = M_IDLE; nr = 0; end
        default: nm = M_IDLE;
      endcase
      rdy  = in_run && !tx_full && !m_wr;
      m_wr = tx_valid && rdy;
      if (m_wr) m_di = tx_data;
      m_tick = in_run && (nm == M_RUN) && tick_req && !m_prev_tick;
      if (m_tick) m_time = time_req;
      m_prev_tick = tick_req;
      nrx = m_rx;
      case (m_rx)
        0: if (in_run && !rx_empty) nrx = 1;
        1: nrx = 2;
        2: begin nrx = 3; m_rxd = data_o; end
        default: if (rx_ready) nrx = 0;
      endcase
      m_rx = nrx;
      m_ph = (nm == m_mode) ? m_ph + 1 : 0;
      m_mode = nm; m_retry = nr;
    end
  endfunction

  task automatic check_all();
    bit ls = (m_mode == M_START) || (m_mode == M_RUN);
    chk("link_start",   16'(link_start),   16'(ls));
    chk("autostart",    16'(autostart),    16'(ls));
    chk("link_disable", 16'(link_disable), 16'((m_mode == M_DIS) || (m_mode == M_FAIL)));
    chk("link_up",      16'(link_up),      16'(m_mode == M_RUN));
    chk("link_fail",    16'(link_fail),    16'(m_mode == M_FAIL));
    chk("retry_cnt",    16'(retry_cnt),    16'(m_retry));
    chk("tx_clk_div",   16'(tx_clk_div),   16'(m_div));
    chk("tx_ready",     16'(tx_ready),     16'((m_mode == M_RUN) && !tx_full && !m_wr));
    chk("wr_data",      16'(wr_data),      16'(m_wr));
    chk("data_i",       16'(data_i),       16'(m_di));
    chk("rd_data",      16'(rd_data),      16'(m_rx == 1));
    chk("rx_valid",     16'(rx_valid),     16'(m_rx == 3));
    chk("rx_data",      16'(rx_data),      16'(m_rxd));
    chk("tick_in",      16'(tick_in),      16'(m_tick));
    chk("time_in",      16'(time_in),      16'(m_time));
  endtask

  task automatic step();
    model_step();
    @(posedge clk_clk);
    @(negedge clk_clk);
    check_all();
  endtask

  task automatic rnd_data();
    tx_valid = 1'($urandom % 2);
    tx_data  = 9'($urandom);
    tx_full  = ($urandom % 4 == 0);
    rx_empty = ($urandom % 3 == 0);
    data_o   = 9'($urandom);
    rx_ready = ($urandom % 3 == 0);
    tick_req = ($urandom % 4 == 0);
    time_req = 8'($urandom);
  endtask

  int rd_cnt;

  initial begin
    reset_reset_n = 1'b0; enable = 1'b0; cfg_tx_clk_div = 7'd0; currentstate = 3'd0;
    tx_valid = 1'b0; tx_data = 9'd0; tx_full = 1'b0; rx_empty = 1'b1; data_o = 9'd0;
    rx_ready = 1'b0; tick_req = 1'b0; time_req = 8'd0;
    model_reset();
    repeat (2) @(negedge clk_clk);
    check_all();
    reset_reset_n = 1'b1;
    repeat (4) step();

    // bring-up: core reaches Run after 40 cycles
    cfg_tx_clk_div = 7'h2B; enable = 1'b1; currentstate = 3'd3;
    for (int i = 0; i < 40; i++) step();
    currentstate = 3'd5;
    step();
    chk("bringup_up", 16'(link_up), 16'd1);
    chk("bringup_div", 16'(tx_clk_div), 16'h2B);

    // random traffic with occasional link loss and host disable
    for (int i = 0; i < 3000; i++) begin
      rnd_data();
      cfg_tx_clk_div = 7'($urandom);
      currentstate = ($urandom % 200 == 0) ? 3'd4 : 3'd5;
      enable = ($urandom % 600 == 0) ? 1'b0 : 1'b1;
      step();
    end

    // settle into RUN with quiet inputs
    enable = 1'b1; currentstate = 3'd5; tx_valid = 1'b0; tick_req = 1'b0;
    rx_empty = 1'b1; rx_ready = 1'b1; tx_full = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("settled_run", 16'(link_up), 16'd1);

    // back-to-back TX words, then a full FIFO
    tx_valid = 1'b1; tx_data = 9'h1A5;
    step();
    tx_data = 9'h0FF;
    for (int i = 0; i < 4; i++) step();
    chk("tx_last_word", 16'(data_i), 16'h0FF);
    tx_full = 1'b1;
    step();
    chk("tx_ready_full", 16'(tx_ready), 16'd0);
    tx_valid = 1'b0; tx_full = 1'b0;

    // RX word held while host is not ready
    rx_ready = 1'b0; rx_empty = 1'b0; data_o = 9'h055; rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rd_data) rd_cnt++;
    end
    chk("rx_single_read", 16'(rd_cnt), 16'd1);
    chk("rx_hold_data", 16'(rx_data), 16'h055);
    rx_ready = 1'b1; rx_empty = 1'b1;
    repeat (3) step();

    // link loss in the same cycle as a tick request
    tick_req = 1'b0; step();
    currentstate = 3'd0; tick_req = 1'b1;
    step();
    chk("drop_no_tick", 16'(tick_in), 16'd0);
    chk("drop_to_start", 16'({link_up, link_start}), 16'b01);
    currentstate = 3'd5; tick_req = 1'b0;
    repeat (3) step();

    // reset asserted mid-RUN forces outputs low immediately
    tick_req = 1'b1; tx_valid = 1'b1;
    step();
    #2 reset_reset_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_link_up", 16'(link_up), 16'd0);
    @(negedge clk_clk);
    step();
    reset_reset_n = 1'b1; tick_req = 1'b0; tx_valid = 1'b0;
    currentstate = 3'd3; enable = 1'b0;
    repeat (4) step();

    // core stuck in Started: three timeouts then FAIL
    enable = 1'b1;
    for (int i = 0; i < 7000; i++) begin
      rnd_data();
      step();
    end
    chk("stuck_fail", 16'(link_fail), 16'd1);
    chk("stuck_retry", 16'(retry_cnt), 16'd3);
    enable = 1'b0;
    repeat (2) step();
    chk("fail_exit", 16'({link_fail, retry_cnt}), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spw_link_ctrl.md
SPW_LINK_CTRL -- requirements
Module: spw_link_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 2000, cycles allowed in START before retry.
REQ-002 SHALL have parameter MAX_RETRY, default 3, failed attempts before FAIL.
REQ-003 SHALL have parameter DIS_CYC, default 16, cycles link_disable is held per DISABLE visit.
REQ-004 SHALL have ports:
 clk_clk  in  1  single clock
 reset_reset_n  in  1  async active-low reset
 enable  in  1  host requests link up
 cfg_tx_clk_div  in  7  TX divider, sampled on IDLE->START
 currentstate  in  3  core FSM state (0 ErrorReset, 1 ErrorWait, 2 Ready, 3 Started, 4 Connecting, 5 Run)
 link_start / autostart / link_disable  out  1 each  core link controls
 tx_clk_div  out  7  registered divider to core
 tx_valid  in  1; tx_data  in  9; tx_ready  out  1  host TX handshake
 wr_data  out  1; data_i  out  9; tx_full  in  1  core TX FIFO side
 rd_data  out  1; data_o  in  9; rx_empty  in  1  core RX FIFO side
 rx_valid  out  1; rx_data  out  9; rx_ready  in  1  host RX handshake
 tick_req  in  1; time_req  in  8  host timecode request
 tick_in  out  1; time_in  out  8  core timecode inputs
 link_up  out  1; link_fail  out  1; retry_cnt  out  2  status

Function
REQ-005 SHALL implement FSM IDLE, START, RUN, DISABLE, FAIL.
REQ-006 IDLE: all core controls 0; enable=1 -> START, latch cfg_tx_clk_div into tx_clk_div, clear timer.
REQ-007 START: link_start=1, autostart=1; timer increments per cycle; currentstate==5 -> RUN, retry_cnt cleared; timer==TIMEOUT_CYC-1 -> DISABLE, retry_cnt+1.
REQ-008 DISABLE: link_disable=1, link_start=autostart=0 for exactly DIS_CYC cycles; then enable=0 -> IDLE, retry_cnt==MAX_RETRY -> FAIL, else START with timer cleared.
REQ-009 RUN: link_up=1, link_start=autostart=1; currentstate!=5 -> START (link loss, retry_cnt unchanged, timer cleared).
REQ-010 FAIL: link_fail=1, link_disable=1; leaves only when enable=0 -> IDLE, retry_cnt cleared.
REQ-011 enable=0 in START or RUN SHALL go to DISABLE next cycle; enable takes priority over currentstate/timeout in the same cycle.
REQ-012 retry_cnt SHALL saturate at MAX_RETRY, never wrap.
REQ-013 tx_ready SHALL be RUN && !tx_full && !wr_data (one bubble after each write so tx_full can update); max 1 word per 2 cycles.
REQ-014 On tx_valid&&tx_ready, next cycle wr_data=1 (one cycle) with data_i=tx_data held until next write.
REQ-015 RX: in RUN, when !rx_empty, no read outstanding and rx_valid=0, SHALL pulse rd_data one cycle; data_o captured the cycle after the pulse into rx_data, rx_valid=1.
REQ-016 rx_valid SHALL hold with rx_data stable until rx_ready=1; cleared that cycle; next rd_data no earlier than the following cycle.
REQ-017 Leaving RUN SHALL abort pending TX acceptance; an outstanding read still completes into rx_data.
REQ-018 tick_req in RUN SHALL produce tick_in=1 for one cycle next cycle with time_in=time_req; tick_req outside RUN ignored; tick_req held high yields one pulse per rising edge.

Reset
REQ-019 reset_reset_n low SHALL asynchronously force IDLE, all outputs 0 (tx_clk_div=0, data_i=0, time_in=0, rx_data=0), timer and retry_cnt 0.
REQ-020 Reset release SHALL be synchronised; first FSM move no earlier than second rising edge after release.

Structure
REQ-021 Package spw_link_ctrl_pkg SHALL hold FSM state enum and currentstate encodings CS_ERRORRESET..CS_RUN.
REQ-022 RX fetch logic (REQ-015..017) SHALL be sub-module spw_rx_fetch; rest is flat.

Verification
REQ-023 enable=1, currentstate=5 after 40 cycles -> link_up=1 at cycle 41, retry_cnt=0, tx_clk_div=cfg value.
REQ-024 enable=1, currentstate stuck 3 -> three START/DISABLE cycles of 2000/16 cycles, then FAIL, link_fail=1, retry_cnt=3; enable=0 -> IDLE.
REQ-025 RUN, tx_valid=1 data 0x1A5,0x0FF, tx_full=0 -> wr_data pulses 2 cycles apart, data_i 0x1A5 then 0x0FF; tx_full=1 -> tx_ready=0.
REQ-026 RUN, rx_empty=0, data_o=0x055, rx_ready=0 for 5 cycles -> single rd_data pulse, rx_data=0x055 held, no second read until rx_ready.
REQ-027 RUN, currentstate drops to 0 simultaneous with tick_req -> START next cycle, no tick_in; reset asserted mid-RUN -> all outputs 0 immediately.
